// File: rtl/ucaspian_axis_pkg.sv
// Shared types and helpers for the word-to-byte AXI-Stream transmitter.
package ucaspian_axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } tx_state_t;

  function automatic int len_width(input int word_bytes);
    return $clog2(word_bytes + 1);
  endfunction

  // Two's-complement negate so that the data bytes plus this byte sum to zero.
  function automatic logic [7:0] csum_negate(input logic [7:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/axis_word_tx.sv
// Serializes word-level messages into an 8-bit AXI-Stream byte stream.
// Optional trailing checksum byte per frame when AXIS_WORD_TX_CHECKSUM_EN is defined.
module axis_word_tx
  import ucaspian_axis_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int MSB_FIRST  = 0,
  parameter int LEN_WIDTH  = len_width(WORD_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*WORD_BYTES-1:0] s_word_tdata,
  input  logic [LEN_WIDTH-1:0]    s_word_tlen,
  input  logic                    s_word_tlast,
  input  logic                    s_word_tvalid,
  output logic                    s_word_tready,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    status_frame_done,
  output logic                    status_len_error
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(WORD_BYTES);
  localparam logic [LEN_WIDTH-1:0] ONE      = LEN_WIDTH'(1);

`ifdef AXIS_WORD_TX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  logic [7:0] csum;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  tx_state_t state, state_next;

  logic [DATA_W-1:0]    shift_reg;
  logic [LEN_WIDTH-1:0] rem;
  logic                 word_last;
  logic                 frame_done_q;
  logic                 len_error_q;
  logic [7:0]           head_byte;
  logic                 len_bad;
  logic [LEN_WIDTH-1:0] len_clamped;
  logic                 word_accept;
  logic                 byte_xfer;
  logic                 frame_end;

  assign head_byte   = (MSB_FIRST != 0) ? shift_reg[DATA_W-1 -: 8] : shift_reg[7:0];
  assign len_bad     = (s_word_tlen == '0) || (int'(s_word_tlen) > WORD_BYTES);
  assign len_clamped = len_bad ? FULL_LEN : s_word_tlen;
  assign word_accept = s_word_tvalid && s_word_tready;
  assign byte_xfer   = m_axis_tvalid && m_axis_tready;

  assign status_frame_done = frame_done_q;
  assign status_len_error  = len_error_q;

  // The last byte of a non-final word opens s_word_tready combinationally so
  // the next word loads on the same edge and the byte stream has no bubble.
  always_comb begin
    state_next    = state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    s_word_tready = 1'b0;
    frame_end     = 1'b0;
    case (state)
      IDLE: begin
        s_word_tready = rst_n;
        if (s_word_tvalid && rst_n) state_next = SEND;
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = head_byte;
        m_axis_tlast  = !CSUM_EN && word_last && (rem == ONE);
        if (m_axis_tready && (rem == ONE)) begin
          if (word_last && CSUM_EN) begin
            state_next = CSUM;
          end else begin
            s_word_tready = rst_n;
            frame_end     = word_last;
            state_next    = s_word_tvalid ? SEND : IDLE;
          end
        end
      end
      CSUM: begin
`ifdef AXIS_WORD_TX_CHECKSUM_EN
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = csum_negate(csum);
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) begin
          frame_end  = 1'b1;
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Word register, remaining-byte count and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      rem          <= '0;
      word_last    <= 1'b0;
      frame_done_q <= 1'b0;
      len_error_q  <= 1'b0;
    end else begin
      state        <= state_next;
      frame_done_q <= frame_end;
      len_error_q  <= word_accept && len_bad;
      if (word_accept) begin
        shift_reg <= s_word_tdata;
        rem       <= len_clamped;
        word_last <= s_word_tlast;
      end else if (byte_xfer && (state == SEND)) begin
        shift_reg <= (MSB_FIRST != 0) ? (shift_reg << 8) : (shift_reg >> 8);
        rem       <= rem - ONE;
      end
    end
  end

`ifdef AXIS_WORD_TX_CHECKSUM_EN
  // Running modulo-256 sum of the frame's data bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'h00;
    end else if ((state == CSUM) && m_axis_tready) begin
      csum <= 8'h00;
    end else if ((state == SEND) && m_axis_tready) begin
      csum <= csum + head_byte;
    end
  end
`endif

endmodule

// File: tb/tb_axis_word_tx.sv
// Self-checking bench for axis_word_tx: directed table, corner sequences, and
// randomized frames under backpressure against a byte-queue reference model.
module tb_axis_word_tx;

  localparam int WB = 4;
  localparam int LW = $clog2(WB + 1);
`ifdef AXIS_WORD_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*WB-1:0] s_word_tdata = '0;
  logic [LW-1:0]   s_word_tlen = '0;
  logic            s_word_tlast = 1'b0;
  logic            s_word_tvalid = 1'b0;
  logic            s_word_tready;
  logic [7:0]      m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic            m_axis_tlast;
  logic            status_frame_done;
  logic            status_len_error;

  axis_word_tx #(.WORD_BYTES(WB), .MSB_FIRST(0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_word_tdata      (s_word_tdata),
    .s_word_tlen       (s_word_tlen),
    .s_word_tlast      (s_word_tlast),
    .s_word_tvalid     (s_word_tvalid),
    .s_word_tready     (s_word_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .status_frame_done (status_frame_done),
    .status_len_error  (status_len_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } obs_t;

  typedef struct {
    logic [31:0]   data;
    logic [LW-1:0] len;
    int            n;
    logic [31:0]   exp;
    int            exp_err;
  } vec_t;

  int    checks = 0;
  int    passes = 0;
  int    cycle = 0;
  int    done_cnt = 0;
  int    err_cnt = 0;
  byte_t exp_q[$];
  obs_t  obs_q[$];
  byte_t exp_b;
  int    model_sum = 0;
  bit    done_pend = 0;
  bit    err_pend = 0;
  bit    stall_prev = 0;
  logic [7:0] stall_data;
  logic       stall_last;
  bit    bp_en = 0;
  int    n_model;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Downstream ready: always-on, or a coin flip each cycle under backpressure.
  always @(posedge clk) begin
    #1;
    m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference model and scoreboard: expected bytes are queued when a word is
  // accepted and popped when a byte transfers.
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      check_output("reset_outputs",
                   {m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_word_tready,
                    status_frame_done, status_len_error}, 32'd0);
      exp_q.delete();
      model_sum  = 0;
      done_pend  = 0;
      err_pend   = 0;
      stall_prev = 0;
    end else begin
      check_output("frame_done_pulse", status_frame_done, done_pend);
      check_output("len_error_pulse", status_len_error, err_pend);
      if (status_frame_done) done_cnt++;
      if (status_len_error) err_cnt++;
      if (stall_prev)
        check_output("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                     {1'b1, stall_last, stall_data});
      done_pend = 0;
      if (m_axis_tvalid && m_axis_tready) begin
        obs_q.push_back('{data: m_axis_tdata, last: m_axis_tlast, cyc: cycle});
        check_output("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check_output("byte_stream", {m_axis_tlast, m_axis_tdata}, {exp_b.last, exp_b.data});
        end
        done_pend = m_axis_tlast;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
      stall_last = m_axis_tlast;
      err_pend = 0;
      if (s_word_tvalid && s_word_tready) begin
        err_pend = (s_word_tlen == 0) || (int'(s_word_tlen) > WB);
        n_model  = err_pend ? WB : int'(s_word_tlen);
        for (int i = 0; i < n_model; i++) begin
          model_sum += int'(s_word_tdata[8*i +: 8]);
          exp_q.push_back('{data: s_word_tdata[8*i +: 8],
                            last: (CS == 0) && s_word_tlast && (i == n_model - 1)});
        end
        if ((CS != 0) && s_word_tlast) begin
          exp_q.push_back('{data: 8'((256 - (model_sum % 256)) % 256), last: 1'b1});
          model_sum = 0;
        end
      end
    end
  end

  // Present one word and hold it until the DUT takes it.
  task automatic apply_stimulus(input logic [31:0] d, input logic [LW-1:0] len, input logic last);
    int budget = 300;
    bit accepted = 0;
    s_word_tdata  = d;
    s_word_tlen   = len;
    s_word_tlast  = last;
    s_word_tvalid = 1'b1;
    while (!accepted && budget > 0) begin
      @(negedge clk);
      accepted = s_word_tready;
      budget--;
    end
    check_output("word_accepted", 32'(accepted), 32'd1);
    @(posedge clk);
    #1;
    s_word_tvalid = 1'b0;
  endtask

  task automatic drain();
    int budget = 600;
    while ((exp_q.size() != 0 || m_axis_tvalid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_output("drain_done", 32'(budget > 0), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] neg_sum(input logic [63:0] bytes, input int n);
    int s = 0;
    for (int j = 0; j < n; j++) s += int'(bytes[8*j +: 8]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // Compare observed bytes from index base against exp; tlast on the final one only.
  task automatic check_frame(input string name, input int base, input logic [63:0] exp, input int n);
    check_output({name, "_count"}, obs_q.size() - base, n);
    for (int j = 0; j < n; j++) begin
      if (obs_q.size() > base + j) begin
        check_output({name, "_byte"}, {obs_q[base+j].last, obs_q[base+j].data},
                     {(j == n - 1), exp[8*j +: 8]});
        check_output({name, "_no_bubble"}, obs_q[base+j].cyc - obs_q[base].cyc, j);
      end
    end
  endtask

  vec_t        vecs[5];
  int          base;
  int          dbase;
  int          ebase;
  logic [63:0] exp64;

  initial begin
    vecs[0] = '{32'h44332211, 3'd4, 4, 32'h44332211, 0};
    vecs[1] = '{32'h04030201, 3'd0, 4, 32'h04030201, 1};
    vecs[2] = '{32'hA5A5A5C3, 3'd1, 1, 32'h000000C3, 0};
    vecs[3] = '{32'h77CCBBAA, 3'd3, 3, 32'h00CCBBAA, 0};
    vecs[4] = '{32'h8899AABB, 3'd7, 4, 32'h8899AABB, 1};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed single-word frames");
    for (int i = 0; i < 5; i++) begin
      base  = obs_q.size();
      dbase = done_cnt;
      ebase = err_cnt;
      apply_stimulus(vecs[i].data, vecs[i].len, 1'b1);
      drain();
      exp64 = {32'h0, vecs[i].exp};
      if (CS != 0) exp64[8*vecs[i].n +: 8] = neg_sum(exp64, vecs[i].n);
      check_frame("table", base, exp64, vecs[i].n + CS);
      check_output("table_done_count", done_cnt - dbase, 32'd1);
      check_output("table_err_count", err_cnt - ebase, vecs[i].exp_err);
    end

    $display("[TB] back-to-back words");
    base = obs_q.size();
    apply_stimulus(32'hDDCCBBAA, 3'd4, 1'b0);
    apply_stimulus(32'h000000EE, 3'd1, 1'b1);
    drain();
    exp64 = 64'h000000EEDDCCBBAA;
    if (CS != 0) exp64[8*5 +: 8] = neg_sum(exp64, 5);
    check_frame("b2b", base, exp64, 5 + CS);

    $display("[TB] reset mid-word");
    base  = obs_q.size();
    dbase = done_cnt;
    apply_stimulus(32'h44332211, 3'd4, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("reset_async_valid", {m_axis_tvalid, m_axis_tlast}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_output("reset_partial_count", obs_q.size() - base, 32'd2);
    if (obs_q.size() >= base + 2)
      check_output("reset_partial_last", {obs_q[base].last, obs_q[base+1].last}, 32'd0);
    base = obs_q.size();
    apply_stimulus(32'h000000FF, 3'd1, 1'b1);
    drain();
    exp64 = 64'hFF;
    if (CS != 0) exp64[15:8] = neg_sum(exp64, 1);
    check_frame("post_reset", base, exp64, 1 + CS);
    check_output("post_reset_done_count", done_cnt - dbase, 32'd1);

`ifdef AXIS_WORD_TX_CHECKSUM_EN
    $display("[TB] checksum frames");
    base = obs_q.size();
    apply_stimulus(32'h00030201, 3'd3, 1'b1);
    drain();
    check_frame("csum_a", base, 64'hFA030201, 4);
    base = obs_q.size();
    apply_stimulus(32'h00000005, 3'd1, 1'b1);
    drain();
    check_frame("csum_b", base, 64'hFB05, 2);
`endif

    $display("[TB] randomized frames with backpressure");
    bp_en = 1;
    dbase = done_cnt;
    for (int w = 0; w < 3; w++)
      apply_stimulus($urandom, LW'($urandom_range(1, WB)), w == 2);
    drain();
    for (int f = 0; f < 20; f++) begin
      int nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++)
        apply_stimulus($urandom, LW'($urandom_range(0, 7)), w == nw - 1);
      drain();
    end
    bp_en = 0;
    check_output("random_done_count", done_cnt - dbase, 32'd21);
    check_output("random_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
